// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: small instruction store, one-cycle read latency, valid/ready issue
// handshake with redirect, halt-opcode detection and an accepted-instruction counter.
module inst_fetch_unit #(
    parameter int unsigned DEPTH   = 16,
    parameter logic [5:0]  HALT_OP = 6'b111111,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          stop,
    input  logic          inst_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic [15:0]   issue_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [31:0]   r_mem [DEPTH];
    logic [1:0]    r_state;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_inst;
    logic [15:0]   r_count;

    logic [1:0]    w_state_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_pc_inc;
    logic [31:0]   w_inst_nxt;
    logic [15:0]   w_count_nxt;
    logic          w_accept;
    logic          w_is_halt;
    logic          w_load_ok;

    assign w_accept  = (r_state == S_ISSUE) && inst_ready;
    assign w_is_halt = (r_inst[31:26] == HALT_OP);
    assign w_pc_inc  = (r_pc == AW'(DEPTH - 1)) ? '0 : r_pc + AW'(1);
    assign w_load_ok = load_we && ((r_state == S_IDLE) || (r_state == S_HALTED));

    // Store is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_count_nxt = r_count;
        // An acceptance counts even when stop aborts in the same cycle.
        if (w_accept) begin
            w_count_nxt = r_count + 16'd1;
        end
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                    w_count_nxt = 16'd0;
                end
            end
            S_FETCH: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_inst_nxt  = r_mem[r_pc];
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_accept) begin
                    if (w_is_halt) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_pc_nxt    = redirect ? redirect_pc : w_pc_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_inst  <= 32'd0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign inst        = r_inst;
    assign pc          = r_pc;
    assign inst_valid  = (r_state == S_ISSUE);
    assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);
    assign halted      = (r_state == S_HALTED);
    assign issue_count = r_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed stimulus pushes expected {inst, pc} pairs,
// a negedge monitor pops and compares on every handshake.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stop;
    logic        inst_ready;
    logic        redirect;
    logic [3:0]  redirect_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic [15:0] issue_count;

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  pc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] model [16];
    int          n_checks = 0;
    int          n_fail   = 0;

    inst_fetch_unit #(.DEPTH(16), .HALT_OP(6'b111111)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        model[a]  = d;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic expect_issue(input logic [31:0] i, input logic [3:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        q.push_back(e);
    endtask

    // Monitor: every handshake seen between edges must match the head of the queue.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_unexpected: got inst %h pc %0d expected no issue", inst, pc);
            end else begin
                mon_e = q.pop_front();
                check("mon_inst", inst, mon_e.inst);
                check("mon_pc", {28'd0, pc}, {28'd0, mon_e.pc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] vpat;
        rst = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stop = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #3;
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_count", {16'd0, issue_count}, 32'd0);
        tick();
        rst = 1'b1;

        // Basic program: two words then a halt word.
        load(4'd0, 32'h2A000005);
        load(4'd1, 32'h28C00002);
        load(4'd2, 32'hFC000000);
        for (int i = 3; i < 16; i++) load(4'(i), 32'h0000_0100 + 32'(i));
        expect_issue(32'h2A000005, 4'd0);
        expect_issue(32'h28C00002, 4'd1);
        expect_issue(32'hFC000000, 4'd2);
        inst_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("seq_valid0", {31'd0, inst_valid}, 32'd0);
        vpat = 7'b0101010;
        for (int i = 1; i < 7; i++) begin
            tick();
            check("seq_valid", {31'd0, inst_valid}, {31'd0, vpat[6-i]});
        end
        check("seq_halted", {31'd0, halted}, 32'd1);
        check("seq_busy", {31'd0, busy}, 32'd0);
        check("seq_count", {16'd0, issue_count}, 32'd3);
        check("seq_pc", {28'd0, pc}, 32'd2);

        // Backpressure: restart from HALTED with ready low.
        inst_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, inst_valid}, 32'd1);
            check("bp_inst", inst, 32'h2A000005);
            check("bp_pc", {28'd0, pc}, 32'd0);
            check("bp_count", {16'd0, issue_count}, 32'd0);
            tick();
        end
        expect_issue(32'h2A000005, 4'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("bp_count_after", {16'd0, issue_count}, 32'd1);
        check("bp_valid_after", {31'd0, inst_valid}, 32'd0);

        // Redirect: ignored while stalled, taken on acceptance.
        tick();
        redirect = 1'b1;
        redirect_pc = 4'd4;
        tick();
        check("rd_nochange_pc", {28'd0, pc}, 32'd1);
        check("rd_nochange_valid", {31'd0, inst_valid}, 32'd1);
        expect_issue(32'h28C00002, 4'd1);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        redirect = 1'b0;
        check("rd_pc", {28'd0, pc}, 32'd4);
        tick();
        check("rd_inst", inst, 32'h0000_0104);
        check("rd_count", {16'd0, issue_count}, 32'd2);

        // Stop with acceptance; concurrent store write must be ignored.
        load_we = 1'b1;
        load_addr = 4'd4;
        load_data = 32'hFC000000;
        expect_issue(32'h0000_0104, 4'd4);
        inst_ready = 1'b1;
        stop = 1'b1;
        tick();
        load_we = 1'b0;
        stop = 1'b0;
        inst_ready = 1'b0;
        check("stop_count", {16'd0, issue_count}, 32'd3);
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_valid", {31'd0, inst_valid}, 32'd0);

        // Wrap: no halt word in store, 17 issues run pc 0..15 then 0.
        load(4'd2, 32'h0000_0102);
        for (int i = 0; i < 17; i++) expect_issue(model[i % 16], 4'(i % 16));
        inst_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (34) tick();
        inst_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("wrap_count", {16'd0, issue_count}, 32'd17);
        check("wrap_pc", {28'd0, pc}, 32'd1);
        check("wrap_busy", {31'd0, busy}, 32'd0);
        check("wrap_q_empty", q.size(), 32'd0);

        // Asynchronous reset mid-ISSUE.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_issue(32'h2A000005, 4'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        check("ar_pre_pc", {28'd0, pc}, 32'd1);
        check("ar_pre_valid", {31'd0, inst_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", {31'd0, inst_valid}, 32'd0);
        check("ar_pc", {28'd0, pc}, 32'd0);
        check("ar_count", {16'd0, issue_count}, 32'd0);
        check("ar_inst", inst, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        #1;
        rst = 1'b1;
        tick();
        check("ar_idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ar_store_kept", inst, 32'h2A000005);
        expect_issue(32'h2A000005, 4'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("ar_resume_count", {16'd0, issue_count}, 32'd1);
        check("final_q_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
